// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that frames one requester's cmd/arg at a time as
// HEADER, id, cmd, arg, checksum and streams the bytes to uart_tx over valid/ready.
//
// state | meaning
// IDLE  | no frame; pick next requester round-robin after rr_last
// HDR   | presenting HEADER
// ID    | presenting granted requester index
// CMD   | presenting captured cmd
// ARG   | presenting captured arg
// CSUM  | presenting id ^ cmd ^ arg; acceptance ends the frame
module uart_tx_scheduler #(
  parameter int                N_REQ  = 3,
  parameter int                BITS_N = 8,
  parameter logic [BITS_N-1:0] HEADER = 8'hAA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BITS_N-1:0]   req_cmd,
  input  logic [N_REQ*BITS_N-1:0]   req_arg,
  output logic [N_REQ-1:0]          req_ack,
  output logic [BITS_N-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, HDR, ID, CMD, ARG, CSUM} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   rr_last;
  logic [ID_W-1:0]   id_q;
  logic [BITS_N-1:0] cmd_q, arg_q;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx, cand;
  logic [N_REQ-1:0]  gnt_onehot;
  logic [BITS_N-1:0] sel_cmd, sel_arg;
  logic [BITS_N-1:0] id_ext;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    gnt_onehot = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_last) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_onehot[gnt_idx] = gnt_found;
  end

  always_comb begin
    sel_cmd = '0;
    sel_arg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_cmd = req_cmd[i*BITS_N +: BITS_N];
        sel_arg = req_arg[i*BITS_N +: BITS_N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
      req_ack <= '0;
    end else begin
      state   <= state_next;
      req_ack <= '0;
      if (state == IDLE && gnt_found) begin
        req_ack <= gnt_onehot;
        rr_last <= gnt_idx;
        id_q    <= gnt_idx;
        cmd_q   <= sel_cmd;
        arg_q   <= sel_arg;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_found) state_next = HDR;
      HDR:     if (tx_ready)  state_next = ID;
      ID:      if (tx_ready)  state_next = CMD;
      CMD:     if (tx_ready)  state_next = ARG;
      ARG:     if (tx_ready)  state_next = CSUM;
      CSUM:    if (tx_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign id_ext = {{(BITS_N-ID_W){1'b0}}, id_q};

  // Outputs decode from registered state, so tx_data cannot move while stalled.
  always_comb begin
    tx_data    = '0;
    tx_valid   = (state != IDLE);
    busy       = (state != IDLE);
    frame_done = (state == CSUM) && tx_ready;
    case (state)
      HDR:     tx_data = HEADER;
      ID:      tx_data = id_ext;
      CMD:     tx_data = cmd_q;
      ARG:     tx_data = arg_q;
      CSUM:    tx_data = id_ext ^ cmd_q ^ arg_q;
      default: tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: framing, round-robin order, backpressure,
// input freezing, mid-frame reset and ignored requests while busy.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_cmd, req_arg;
  logic [2:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] bytes[$];
  logic [2:0] acks[$];
  int         fd_cyc[$];
  int         fd_cnt = 0;
  logic [7:0] fd_byte;

  uart_tx_scheduler #(.N_REQ(3), .BITS_N(8), .HEADER(8'hAA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_arg(req_arg),
    .req_ack(req_ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log accepted bytes, acks and frame ends mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) bytes.push_back(tx_data);
    if (req_ack != 3'b000) acks.push_back(req_ack);
    if (frame_done) begin
      fd_cnt++;
      fd_cyc.push_back(cyc);
      fd_byte = tx_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    bytes.delete();
    acks.delete();
    fd_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req_valid = 3'b000;
    tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_frames(input int n, input string name);
    int t = 0;
    while (fd_cnt < n && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (fd_cnt < n) begin
      failures++;
      $display("FAIL %s_timeout frames=%0d required=%0d", name, fd_cnt, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 3'b111;
    req_cmd = '0;
    req_arg = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0)   begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (req_ack !== 3'b000)  begin failures++; $display("FAIL reset_req_ack got=%b exp=000", req_ack); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    tick();
    req_valid = 3'b000;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_single;
    logic [7:0] exp[5] = '{8'hAA, 8'h00, 8'h12, 8'h34, 8'h26};
    apply_reset();
    req_cmd = 24'h000012;
    req_arg = 24'h000034;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1)  begin failures++; $display("FAIL single_first_valid got=%b exp=1", tx_valid); end
    checks++; if (tx_data !== 8'hAA)  begin failures++; $display("FAIL single_first_data got=%h exp=aa", tx_data); end
    checks++; if (req_ack !== 3'b001) begin failures++; $display("FAIL single_ack got=%b exp=001", req_ack); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_frames(1, "single");
    tick();
    tick();
    checks++; if (bytes.size() != 5) begin failures++; $display("FAIL single_len got=%0d exp=5", bytes.size()); end
    for (int i = 0; i < 5 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, bytes[i], exp[i]); end
    end
    checks++; if (acks.size() != 1)  begin failures++; $display("FAIL single_ack_count got=%0d exp=1", acks.size()); end
    checks++; if (fd_cnt != 1)       begin failures++; $display("FAIL single_done_count got=%0d exp=1", fd_cnt); end
    checks++; if (fd_byte !== 8'h26) begin failures++; $display("FAIL single_done_byte got=%h exp=26", fd_byte); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_ack[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [7:0] exp_f1[5]  = '{8'hAA, 8'h01, 8'h11, 8'h21, 8'h31};
    logic [7:0] exp_f2[5]  = '{8'hAA, 8'h02, 8'h12, 8'h22, 8'h32};
    int t = 0;
    apply_reset();
    req_cmd = 24'h121110;
    req_arg = 24'h222120;
    req_valid = 3'b111;
    while (fd_cnt < 4 && t < 60) begin
      tick();
      t++;
    end
    req_valid = 3'b000;
    checks++; if (fd_cnt < 4) begin failures++; $display("FAIL rr_timeout frames=%0d required=4", fd_cnt); end
    tick();
    tick();
    checks++; if (acks.size() != 4) begin failures++; $display("FAIL rr_ack_count got=%0d exp=4", acks.size()); end
    for (int i = 0; i < 4 && i < acks.size(); i++) begin
      checks++;
      if (acks[i] !== exp_ack[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, acks[i], exp_ack[i]); end
    end
    checks++; if (bytes.size() != 20) begin failures++; $display("FAIL rr_len got=%0d exp=20", bytes.size()); end
    for (int i = 0; i < 5 && i + 10 < bytes.size(); i++) begin
      checks++;
      if (bytes[i+5] !== exp_f1[i])  begin failures++; $display("FAIL rr_f1_byte%0d got=%h exp=%h", i, bytes[i+5], exp_f1[i]); end
      checks++;
      if (bytes[i+10] !== exp_f2[i]) begin failures++; $display("FAIL rr_f2_byte%0d got=%h exp=%h", i, bytes[i+10], exp_f2[i]); end
    end
    if (fd_cyc.size() >= 4) begin
      checks++;
      if (fd_cyc[3] - fd_cyc[0] != 18) begin
        failures++; $display("FAIL rr_period got=%0d exp=18", fd_cyc[3] - fd_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp[5] = '{8'hAA, 8'h00, 8'h12, 8'h34, 8'h26};
    int t = 0;
    apply_reset();
    req_cmd = 24'h000012;
    req_arg = 24'h000034;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    while (!(tx_valid && tx_data == 8'h12) && t < 10) begin
      tick();
      t++;
    end
    checks++; if (!(tx_valid && tx_data == 8'h12)) begin failures++; $display("FAIL bp_reach_cmd got=%h exp=12", tx_data); end
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h12}) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/12", i, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    wait_frames(1, "bp");
    tick();
    checks++; if (bytes.size() != 5) begin failures++; $display("FAIL bp_len got=%0d exp=5", bytes.size()); end
    for (int i = 0; i < 5 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, bytes[i], exp[i]); end
    end
  endtask

  task automatic test_freeze;
    int t = 0;
    apply_reset();
    req_cmd = 24'h000012;
    req_arg = 24'h000034;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    while (!(tx_valid && tx_data == 8'h34) && t < 10) begin
      tick();
      t++;
    end
    checks++; if (!(tx_valid && tx_data == 8'h34)) begin failures++; $display("FAIL frz_reach_arg got=%h exp=34", tx_data); end
    req_cmd = 24'h0000FF;
    wait_frames(1, "frz");
    tick();
    checks++; if (bytes.size() != 5) begin failures++; $display("FAIL frz_len got=%0d exp=5", bytes.size()); end
    if (bytes.size() == 5) begin
      checks++; if (bytes[2] !== 8'h12) begin failures++; $display("FAIL frz_cmd got=%h exp=12", bytes[2]); end
      checks++; if (bytes[4] !== 8'h26) begin failures++; $display("FAIL frz_csum got=%h exp=26", bytes[4]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp[5] = '{8'hAA, 8'h01, 8'h11, 8'h21, 8'h31};
    int t = 0;
    apply_reset();
    req_cmd = 24'h001112;
    req_arg = 24'h002134;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    while (!(tx_valid && tx_data == 8'h34) && t < 10) begin
      tick();
      t++;
    end
    checks++; if (!(tx_valid && tx_data == 8'h34)) begin failures++; $display("FAIL rstm_reach_arg got=%h exp=34", tx_data); end
    rst = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstm_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rstm_busy got=%b exp=0", busy); end
    rst = 1'b0;
    clear_log();
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    wait_frames(1, "rstm");
    tick();
    checks++; if (acks.size() != 1 || acks[0] !== 3'b010) begin
      failures++; $display("FAIL rstm_ack count=%0d first=%b exp=1/010", acks.size(), (acks.size() > 0) ? acks[0] : 3'b000);
    end
    checks++; if (bytes.size() != 5) begin failures++; $display("FAIL rstm_len got=%0d exp=5", bytes.size()); end
    for (int i = 0; i < 5 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp[i]) begin failures++; $display("FAIL rstm_byte%0d got=%h exp=%h", i, bytes[i], exp[i]); end
    end
  endtask

  task automatic test_skip;
    apply_reset();
    req_cmd = 24'h001112;
    req_arg = 24'h002134;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    wait_frames(1, "skip");
    repeat (4) tick();
    checks++; if (acks.size() != 1) begin failures++; $display("FAIL skip_ack_count got=%0d exp=1", acks.size()); end
    if (acks.size() > 0) begin
      checks++; if (acks[0] !== 3'b001) begin failures++; $display("FAIL skip_ack got=%b exp=001", acks[0]); end
    end
    checks++; if (bytes.size() != 5) begin failures++; $display("FAIL skip_len got=%0d exp=5", bytes.size()); end
    checks++; if (fd_cnt != 1)       begin failures++; $display("FAIL skip_frames got=%0d exp=1", fd_cnt); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL skip_busy got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 3'b000;
    req_cmd = '0;
    req_arg = '0;
    tx_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_freeze();
    test_reset_mid();
    test_skip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
